coprocessor_unit: RTL and testbench



---
 rtl/coprocessor_unit.sv | 120 ++++++++++++
 tb/tb_coprocessor_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/coprocessor_unit.sv
// coprocessor_unit: 33-clock unsigned 32-bit multiply (low word) / divide (quotient) coprocessor.
// Divider and alu are built only when COPROC_DIV_EN is defined; otherwise op=1 returns 0.
module adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);
    assign sum_o = a_i + b_i;
endmodule

`ifdef COPROC_DIV_EN
module alu (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sub_i,
    output logic [31:0] y_o,
    output logic        carry_o
);
    assign {carry_o, y_o} = {1'b0, a_i} + {1'b0, sub_i ? ~b_i : b_i} + {32'b0, sub_i};
endmodule
`endif

module coprocessor_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        last_q, last_d, op_q, op_d, done_q, done_d;
    logic [31:0] acc_q, acc_d, x_q, x_d, y_q, y_d, result_q, result_d;
    logic [31:0] sum, acc_step, x_step, y_step, quot;

    adder u_adder (.a_i(acc_q), .b_i(y_q[0] ? x_q : 32'h0), .sum_o(sum));

`ifdef COPROC_DIV_EN
    logic [31:0] rem_sh, diff;
    logic        carry, ge;
    assign rem_sh = {acc_q[30:0], x_q[31]};
    alu u_alu (.a_i(rem_sh), .b_i(y_q), .sub_i(1'b1), .y_o(diff), .carry_o(carry));
    // The bit shifted out of the remainder is the 33rd bit of the trial dividend
    assign ge       = acc_q[31] | carry;
    assign acc_step = op_q ? (ge ? diff : rem_sh) : sum;
    assign x_step   = {x_q[30:0], op_q & ge};
    assign y_step   = op_q ? y_q : {1'b0, y_q[31:1]};
    assign quot     = x_q;
`else
    assign acc_step = sum;
    assign x_step   = {x_q[30:0], 1'b0};
    assign y_step   = {1'b0, y_q[31:1]};
    assign quot     = 32'h0;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;

    always_comb
        state_d = state_q == IDLE ? (start ? BUSY : IDLE) :
                  state_q == BUSY ? (last_q ? DONE : BUSY) :
                  (start ? DONE : IDLE);

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        op_d   = op_q;
        acc_d  = acc_q;
        x_d    = x_q;
        y_d    = y_q;
        if (state_q == IDLE && start) begin
            cnt_d  = 5'd0;
            last_d = 1'b0;
            op_d   = op;
            acc_d  = 32'h0;
            x_d    = a;
            y_d    = b;
        end else if (state_q == BUSY && !last_q) begin
            cnt_d  = cnt_q + 5'd1;
            last_d = cnt_q == 5'd31;
            acc_d  = acc_step;
            x_d    = x_step;
            y_d    = y_step;
        end
    end

    always_comb begin
        result_d = (state_q == BUSY && last_q) ? (op_q ? quot : acc_q) : result_q;
        done_d   = state_d == DONE;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt_q    <= 5'd0;
            last_q   <= 1'b0;
            op_q     <= 1'b0;
            acc_q    <= 32'h0;
            x_q      <= 32'h0;
            y_q      <= 32'h0;
            result_q <= 32'h0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            done_q   <= done_d;
        end

    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_coprocessor_unit.sv
// tb_coprocessor_unit: vector table plus scoreboard queue for coprocessor_unit latency and results.
module tb_coprocessor_unit;
    logic        clk, reset, start, op, done;
    logic [31:0] a, b, result;

    coprocessor_unit dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .op(op), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic logic [31:0] dv(input logic [31:0] x);
`ifdef COPROC_DIV_EN
        return x;
`else
        return 32'h0 & x;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                          input logic [31:0] vexp);
        @(negedge clk);
        a = va;
        b = vb;
        op = vop;
        start = 1'b1;
        exp_q.push_back(vexp);
    endtask

    // The next rising edge must be the launch edge E0
    task automatic wait_result(input string nm, input bit chg);
        int lat;
        lat = 0;
        @(posedge clk);
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (done) lat = k;
            if (chg && k == 10) begin
                a = $urandom;
                b = $urandom;
                op = ~op;
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'd33);
        last_exp = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk({nm, " result"}, result, last_exp);
    endtask

    task automatic release_chk(input string nm);
        @(posedge clk);
        #1;
        chk({nm, " hold done"}, {31'b0, done}, 32'd1);
        chk({nm, " hold result"}, result, last_exp);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, " drop done"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'd7,          32'd6,          1'b0, 32'd42};
        vecs[1] = '{32'hFFFF_FFFF,  32'd2,          1'b0, 32'hFFFF_FFFE};
        vecs[2] = '{32'h0001_0000,  32'h0001_0000,  1'b0, 32'h0};
        vecs[3] = '{32'h1234_5678,  32'd9,          1'b0, 32'hA3D7_0A38};
        vecs[4] = '{32'd100,        32'd7,          1'b1, dv(32'd14)};
        vecs[5] = '{32'hFFFF_FFFF,  32'd1,          1'b1, dv(32'hFFFF_FFFF)};
        vecs[6] = '{32'd5,          32'd9,          1'b1, dv(32'd0)};
        vecs[7] = '{32'd123,        32'd0,          1'b1, dv(32'hFFFF_FFFF)};
        vecs[8] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, dv(32'd1)};
        vecs[9] = '{32'hFFFF_FFF0,  32'd3,          1'b1, dv(32'h5555_5550)};

        reset = 1'b1;
        start = 1'b1;
        a = 32'd7;
        b = 32'd6;
        op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(32'd42);
        wait_result("reset_launch", 1'b0);
        release_chk("reset_launch");

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
            wait_result($sformatf("vec%0d", i), 1'b0);
            release_chk($sformatf("vec%0d", i));
        end

        launch(32'd7, 32'd6, 1'b0, 32'd42);
        wait_result("latch", 1'b1);
        release_chk("latch");

        @(negedge clk);
        a = 32'd7;
        b = 32'd6;
        op = 1'b0;
        start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort done", {31'b0, done}, 32'd0);
        chk("abort result", result, 32'd0);
        a = 32'd3;
        b = 32'd5;
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(32'd15);
        wait_result("relaunch", 1'b0);
        release_chk("relaunch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
